// File: rtl/sysbus_rr_arbiter_if.sv
// Sysbus arbiter signal bundle: client-facing bid/request/response lanes plus the
// shared bus channels. The arbiter uses the slave view; clients and the bus model use the master view.
interface sysbus_rr_arbiter_if #(
  parameter int N_CLIENTS      = 4,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic [N_CLIENTS-1:0]                cli_bid;
  logic [N_CLIENTS-1:0]                cli_grant;
  logic [N_CLIENTS-1:0]                cli_reqcyc;
  logic [N_CLIENTS*BUS_DATA_WIDTH-1:0] cli_req;
  logic [N_CLIENTS*BUS_TAG_WIDTH-1:0]  cli_reqtag;
  logic [N_CLIENTS-1:0]                cli_reqack;
  logic [N_CLIENTS-1:0]                cli_respcyc;
  logic [N_CLIENTS-1:0]                cli_respack;
  logic [BUS_DATA_WIDTH-1:0]           cli_resp;
  logic [BUS_TAG_WIDTH-1:0]            cli_resptag;

  logic                                bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0]           bus_req;
  logic [BUS_TAG_WIDTH-1:0]            bus_reqtag;
  logic                                bus_reqack;
  logic                                bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0]           bus_resp;
  logic [BUS_TAG_WIDTH-1:0]            bus_resptag;
  logic                                bus_respack;
  logic                                resp_orphan;

  modport slave (
    input  cli_bid, cli_reqcyc, cli_req, cli_reqtag, cli_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output cli_grant, cli_reqack, cli_respcyc, cli_resp, cli_resptag,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack, resp_orphan
  );

  modport master (
    output cli_bid, cli_reqcyc, cli_req, cli_reqtag, cli_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  cli_grant, cli_reqack, cli_respcyc, cli_resp, cli_resptag,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack, resp_orphan
  );
endinterface

// File: rtl/sysbus_rr_arbiter.sv
// N-client round-robin Sysbus arbiter: grants one owner at a time, routes its request
// channel to the bus and the response channel back, and holds ownership across response bursts.
module sysbus_rr_arbiter #(
  parameter int N_CLIENTS      = 4,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int RESP_BEATS     = 8
) (
  input logic            clk,
  input logic            reset,
  sysbus_rr_arbiter_if.slave sb
);
  localparam int IDX_W = $clog2(N_CLIENTS);
  localparam int CNT_W = $clog2(RESP_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       owner_reg, owner_next;
  logic [IDX_W-1:0]       prio_ptr_reg, prio_ptr_next;
  logic [CNT_W-1:0]       beat_cnt_reg, beat_cnt_next;
  logic                   burst_active_reg, burst_active_next;
  logic                   resp_orphan_reg, resp_orphan_next;
  logic [N_CLIENTS-1:0]   grant_reg, grant_next;

  logic [IDX_W-1:0]       pick_idx, cand_idx;
  logic                   pick_valid;
  logic                   owning, owner_bid, owner_respack, beat;

  logic [BUS_DATA_WIDTH-1:0] req_arr [N_CLIENTS];
  logic [BUS_TAG_WIDTH-1:0]  tag_arr [N_CLIENTS];

  assign owning        = (state_reg == ST_OWN);
  assign owner_bid     = sb.cli_bid[owner_reg];
  assign owner_respack = sb.cli_respack[owner_reg];
  assign beat          = owning & sb.bus_respcyc & owner_respack;

  // Scan downward so the candidate closest to prio_ptr is the last one written.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = prio_ptr_reg;
    cand_idx   = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      cand_idx = IDX_W'((int'(prio_ptr_reg) + k) % N_CLIENTS);
      if (sb.cli_bid[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      owner_reg        <= '0;
      prio_ptr_reg     <= '0;
      beat_cnt_reg     <= '0;
      burst_active_reg <= 1'b0;
      resp_orphan_reg  <= 1'b0;
      grant_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      owner_reg        <= owner_next;
      prio_ptr_reg     <= prio_ptr_next;
      beat_cnt_reg     <= beat_cnt_next;
      burst_active_reg <= burst_active_next;
      resp_orphan_reg  <= resp_orphan_next;
      grant_reg        <= grant_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    owner_next        = owner_reg;
    prio_ptr_next     = prio_ptr_reg;
    beat_cnt_next     = beat_cnt_reg;
    burst_active_next = burst_active_reg;
    resp_orphan_next  = resp_orphan_reg | (sb.bus_respcyc & ~owning);
    grant_next        = '0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_next           = pick_idx;
          grant_next[pick_idx] = 1'b1;
          state_next           = ST_OWN;
        end
      end
      ST_OWN: begin
        grant_next = grant_reg;
        if (beat) begin
          if (beat_cnt_reg == CNT_W'(RESP_BEATS - 1)) begin
            beat_cnt_next     = '0;
            burst_active_next = 1'b0;
          end else begin
            beat_cnt_next     = beat_cnt_reg + 1'b1;
            burst_active_next = 1'b1;
          end
        end
        // Release looks at the post-beat burst state so a final beat and a bid
        // drop in the same cycle go straight to DRAIN.
        if (!owner_bid && !burst_active_next) begin
          state_next = ST_DRAIN;
          grant_next = '0;
        end
      end
      ST_DRAIN: begin
        prio_ptr_next = (owner_reg == IDX_W'(N_CLIENTS - 1)) ? '0 : owner_reg + 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_client
    assign req_arr[gi]        = sb.cli_req[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    assign tag_arr[gi]        = sb.cli_reqtag[gi*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
    assign sb.cli_reqack[gi]  = grant_reg[gi] & sb.bus_reqack;
    assign sb.cli_respcyc[gi] = grant_reg[gi] & sb.bus_respcyc;
  end

  assign sb.cli_grant   = grant_reg;
  assign sb.bus_reqcyc  = owning & sb.cli_reqcyc[owner_reg];
  assign sb.bus_req     = owning ? req_arr[owner_reg] : '0;
  assign sb.bus_reqtag  = owning ? tag_arr[owner_reg] : '0;
  assign sb.bus_respack = owning & owner_respack;
  assign sb.cli_resp    = sb.bus_resp;
  assign sb.cli_resptag = sb.bus_resptag;
  assign sb.resp_orphan = resp_orphan_reg;
endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Directed bench for sysbus_rr_arbiter: expectations are queued as stimulus is
// driven and popped when the DUT outputs are sampled.
module tb_sysbus_rr_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int T = 13;
  localparam int B = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sysbus_rr_arbiter_if #(.N_CLIENTS(N), .BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T)) sb ();

  sysbus_rr_arbiter #(.N_CLIENTS(N), .BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T), .RESP_BEATS(B)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic expect_v(input string name, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0h, required an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val)
      else begin
        fails++;
        $error("FAIL %s: observed %0h, required %0h", e.name, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    sb.cli_bid     = '0;
    sb.cli_reqcyc  = '0;
    sb.cli_respack = '0;
    sb.bus_reqack  = 1'b0;
    sb.bus_respcyc = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] cdata(input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_1111_0000_1111);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ptr;
    int gap;
    int exp_c;
    int acked;
    logic ack;

    // Reset state: response beat during reset must not flag orphan.
    clear_inputs();
    sb.cli_req     = '0;
    sb.cli_reqtag  = '0;
    sb.bus_resp    = 64'hDEAD_BEEF_0123_4567;
    sb.bus_resptag = 13'h1ABC;
    reset          = 1'b1;
    sb.bus_respcyc = 1'b1;
    sb.cli_respack = '1;
    repeat (3) tick();
    settle();
    expect_v("rst_grant", 0);                      check(64'(sb.cli_grant));
    expect_v("rst_bus_reqcyc", 0);                 check(64'(sb.bus_reqcyc));
    expect_v("rst_bus_respack", 0);                check(64'(sb.bus_respack));
    expect_v("rst_cli_respcyc", 0);                check(64'(sb.cli_respcyc));
    expect_v("rst_orphan", 0);                     check(64'(sb.resp_orphan));
    expect_v("rst_cli_resp", 64'hDEAD_BEEF_0123_4567); check(sb.cli_resp);
    expect_v("rst_cli_resptag", 64'h1ABC);         check(64'(sb.cli_resptag));
    clear_inputs();
    reset = 1'b0;
    tick();

    // Single client 2, other clients also present requests to prove the mux.
    for (int i = 0; i < N; i++) begin
      sb.cli_req[i*W +: W]    = cdata(i);
      sb.cli_reqtag[i*T +: T] = T'(100 + i);
    end
    sb.cli_reqcyc = '1;
    sb.cli_bid    = 4'b0100;
    settle();
    expect_v("single_grant_same_cycle", 0);        check(64'(sb.cli_grant));
    tick();
    expect_v("single_grant", 4'b0100);             check(64'(sb.cli_grant));
    expect_v("single_bus_reqcyc", 1);              check(64'(sb.bus_reqcyc));
    expect_v("single_bus_req", cdata(2));          check(sb.bus_req);
    expect_v("single_bus_reqtag", 102);            check(64'(sb.bus_reqtag));
    sb.bus_reqack = 1'b1;
    settle();
    expect_v("single_reqack", 4'b0100);            check(64'(sb.cli_reqack));
    sb.bus_reqack = 1'b0;
    sb.cli_bid    = '0;
    tick();
    expect_v("single_drain_grant", 0);             check(64'(sb.cli_grant));
    expect_v("single_drain_reqcyc", 0);            check(64'(sb.bus_reqcyc));
    tick();
    expect_v("single_idle_req", 0);                check(sb.bus_req);
    sb.cli_reqcyc = '0;

    // Round-robin fairness from reset with every client bidding.
    do_reset();
    sb.cli_bid = '1;
    ptr = 0;
    for (int r = 0; r < 5; r++) begin
      exp_c = ptr;
      gap   = 0;
      while (sb.cli_grant == '0 && gap < 8) begin
        gap++;
        tick();
      end
      expect_v("rr_grant", 64'(1) << exp_c);       check(64'(sb.cli_grant));
      if (r > 0) begin
        expect_v("rr_gap", 2);                     check(64'(gap));
      end
      sb.bus_reqack = 1'b1;
      settle();
      expect_v("rr_reqack", 64'(1) << exp_c);      check(64'(sb.cli_reqack));
      sb.bus_reqack      = 1'b0;
      sb.cli_bid[exp_c]  = 1'b0;
      ptr                = (exp_c + 1) % N;
      tick();
      sb.cli_bid[exp_c]  = 1'b1;
    end
    sb.cli_bid = '0;
    repeat (3) tick();

    // Wrap-around: owner 3 releases, then 0 and 2 bid together.
    sb.cli_bid = 4'b1000;
    tick();
    expect_v("wrap_grant3", 4'b1000);              check(64'(sb.cli_grant));
    sb.cli_bid = '0;
    tick();
    sb.cli_bid = 4'b0101;
    tick();
    expect_v("wrap_idle_grant", 0);                check(64'(sb.cli_grant));
    tick();
    expect_v("wrap_grant0", 4'b0001);              check(64'(sb.cli_grant));
    sb.cli_bid = '0;
    repeat (3) tick();

    // Burst hold: 10 beats presented, beats 2 and 5 stalled, bid drops after 3 acked.
    sb.cli_bid = 4'b0010;
    tick();
    expect_v("burst_grant", 4'b0010);              check(64'(sb.cli_grant));
    acked = 0;
    for (int j = 0; j < 10; j++) begin
      ack            = !(j == 2 || j == 5);
      sb.bus_respcyc = 1'b1;
      sb.bus_resp    = 64'hB000 + 64'(j);
      sb.cli_respack = 4'b1101 | {2'b00, ack, 1'b0};
      if (acked == 3) sb.cli_bid = '0;
      settle();
      expect_v("burst_hold_grant", 4'b0010);       check(64'(sb.cli_grant));
      expect_v("burst_cli_respcyc", 4'b0010);      check(64'(sb.cli_respcyc));
      expect_v("burst_bus_respack", 64'(ack));     check(64'(sb.bus_respack));
      expect_v("burst_cli_resp", 64'hB000 + 64'(j)); check(sb.cli_resp);
      if (ack) acked++;
      tick();
    end
    sb.bus_respcyc = 1'b0;
    sb.cli_respack = '0;
    settle();
    expect_v("burst_release_grant", 0);            check(64'(sb.cli_grant));
    expect_v("burst_no_orphan", 0);                check(64'(sb.resp_orphan));
    tick();

    // Orphan response in IDLE.
    sb.bus_respcyc = 1'b1;
    sb.cli_respack = '1;
    settle();
    expect_v("orphan_respack", 0);                 check(64'(sb.bus_respack));
    expect_v("orphan_cli_respcyc", 0);             check(64'(sb.cli_respcyc));
    expect_v("orphan_not_yet", 0);                 check(64'(sb.resp_orphan));
    tick();
    sb.bus_respcyc = 1'b0;
    sb.cli_respack = '0;
    settle();
    expect_v("orphan_set", 1);                     check(64'(sb.resp_orphan));
    tick();
    expect_v("orphan_sticky", 1);                  check(64'(sb.resp_orphan));

    // Reset mid-burst.
    do_reset();
    settle();
    expect_v("rst2_orphan_clear", 0);              check(64'(sb.resp_orphan));
    sb.cli_bid = 4'b1000;
    tick();
    expect_v("mid_grant3", 4'b1000);               check(64'(sb.cli_grant));
    for (int j = 0; j < 4; j++) begin
      sb.bus_respcyc = 1'b1;
      sb.cli_respack = 4'b1000;
      if (j == 3) reset = 1'b1;
      tick();
    end
    expect_v("mid_rst_grant", 0);                  check(64'(sb.cli_grant));
    expect_v("mid_rst_orphan", 0);                 check(64'(sb.resp_orphan));
    reset          = 1'b0;
    sb.cli_bid     = '0;
    sb.cli_respack = '1;
    settle();
    expect_v("mid_beat_respack", 0);               check(64'(sb.bus_respack));
    tick();
    sb.bus_respcyc = 1'b0;
    sb.cli_respack = '0;
    settle();
    expect_v("mid_orphan_set", 1);                 check(64'(sb.resp_orphan));
    sb.cli_bid = 4'b1100;
    tick();
    expect_v("mid_ptr0_grant2", 4'b0100);          check(64'(sb.cli_grant));
    sb.cli_bid = '0;
    tick();
    expect_v("mid_release_no_burst", 0);           check(64'(sb.cli_grant));
    tick();

    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: observed %0d entries, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sysbus_rr_arbiter.md
# sysbus_rr_arbiter

N-client round-robin arbiter and multiplexer for the shared Sysbus. It replaces the fixed two-client instruction/data cache arbitration. Clients bid for ownership, and the block grants one client at a time. It routes that client's request channel to the bus and the bus response channel back to it, and it holds ownership until the client releases the bus and any response burst in flight has completed.

## Interface
- N_CLIENTS, 4: number of bus clients, range 2..8.
- BUS_DATA_WIDTH, 64: data width of req/resp.
- BUS_TAG_WIDTH, 13: tag width of reqtag/resptag.
- RESP_BEATS, 8: beats per response burst (one 512-bit line at 64 bits/beat).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cli_bid  in  N_CLIENTS  per-client ownership request.
- cli_grant  out  N_CLIENTS  registered one-hot (or zero) owner.
- cli_reqcyc  in  N_CLIENTS  per-client request valid.
- cli_req  in  N_CLIENTS*BUS_DATA_WIDTH  packed request data; client i at [i*W +: W].
- cli_reqtag  in  N_CLIENTS*BUS_TAG_WIDTH  packed request tags.
- cli_reqack  out  N_CLIENTS  bus_reqack routed to owner only.
- cli_respcyc  out  N_CLIENTS  bus_respcyc routed to owner only.
- cli_respack  in  N_CLIENTS  per-client response acknowledge.
- cli_resp  out  BUS_DATA_WIDTH  bus_resp broadcast.
- cli_resptag  out  BUS_TAG_WIDTH  bus_resptag broadcast.
- bus_reqcyc, bus_req, bus_reqtag  out  1/W/T  owner's request channel; zero when no owner.
- bus_reqack  in  1.
- bus_respcyc, bus_resp, bus_resptag  in  1/W/T.
- bus_respack  out  1  owner's cli_respack; 0 when no owner.
- resp_orphan  out  1  sticky: response beat arrived with no owner.

## Operation
- State machine IDLE -> OWN -> DRAIN -> IDLE.
- IDLE:
  - cli_grant = 0.
  - If any cli_bid is set, select the first set bid scanning from prio_ptr upward with wrap-around.
  - Load owner, set the grant bit, go to OWN.
- OWN:
  - The bus channels mux combinationally from the registered owner index.
  - Beat counter: increments on bus_respcyc & bus_respack. On reaching RESP_BEATS it clears to 0 and `burst_active` clears. The first beat sets `burst_active`.
  - When cli_bid[owner] = 0 and burst_active = 0, go to DRAIN.
- DRAIN:
  - One-cycle turnaround; cli_grant = 0; bus_reqcyc = 0.
  - prio_ptr <= (owner + 1) mod N_CLIENTS. Go to IDLE.
- A client dropping its bid mid-burst does not release the bus. Ownership holds until the beat counter wraps.
- A bus_respcyc beat in IDLE/DRAIN sets resp_orphan; bus_respack stays 0. Only reset clears resp_orphan.
- cli_bid from non-owners is ignored while in OWN/DRAIN. No preemption.
- Reset values:
  - State IDLE, prio_ptr 0, owner 0, counter 0, burst_active 0, resp_orphan 0.
  - All outputs 0 except the broadcast cli_resp/cli_resptag, which follow the bus inputs.
- Reset mid-burst abandons ownership immediately. Remaining beats then flag resp_orphan.

## Timing
- Grant latency: bid asserted in cycle t while IDLE -> cli_grant high in t+1.
- Request and response routing is zero-latency combinational from the registered grant.
- Release: owner drops its bid at t with no burst active -> DRAIN at t+1 (grant low) -> IDLE at t+2 -> next grant at t+3.
- Minimum back-to-back gap between different owners: 2 grant-low cycles.
- Beat counter width: $clog2(RESP_BEATS+1). It compares against RESP_BEATS and never overflows.
- A beat without respack does not count; the bus re-presents it.
- If the final beat and the bid drop occur in the same cycle, DRAIN is entered the next cycle.

## Test plan
- Single client: N=4, client 2 bids at cycle 5 -> cli_grant=4'b0100 at cycle 6. Its req/tag appear on the bus with bus_reqack returned only to client 2. Bid drops at 10 -> grant 0 at 11.
- Round-robin fairness: all four bid continuously, each releasing after one request -> grant order 0,1,2,3,0 with a 2-cycle gap between grants.
- Burst hold: client 1 drops its bid after beat 3 of 8 -> grant stays until beat 8 is acked, then DRAIN. Beats with respack=0 are not counted (10 beats presented, 2 stalled -> release after the 10th).
- Orphan response: bus_respcyc=1 while IDLE -> resp_orphan=1 next cycle and held; bus_respack=0; no cli_respcyc asserted.
- Reset mid-burst: reset at beat 4 -> next cycle grant 0, counter 0, state IDLE, prio_ptr 0. A subsequent beat sets resp_orphan.
- Wrap-around priority: owner 3 releases, then clients 0 and 2 bid together -> client 0 granted.
